alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; legal 8..64, power of two.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 A, B  input  WIDTH each  operands.
REQ-007 op  input  4  opcode (alu_pkg::alu_op_e).
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 Q  output  WIDTH  primary result.
REQ-011 R  output  WIDTH  secondary result: product high half (MULU), remainder (DIVU), else 0.
REQ-012 overflow, less, equal, greater, zero  output  1 each  result flags.

Function
REQ-013 Opcodes, values 0..14 in order: ADD, SUB, NEG, SCMP, UCMP, AND, OR, XOR, NOT, ARS, LRS, LROT, RROT, MULU, DIVU; value 15 illegal.
REQ-014 ADD Q=A+B; SUB Q=A-B; NEG Q=-B; NOT Q=~B; AND/OR/XOR bitwise A,B; SCMP/UCMP Q=A-B.
REQ-015 Shifts/rotates act on B by amount s=A[clog2(WIDTH)-1:0]; ARS sign-fills, LRS zero-fills, LROT left, RROT right; s=0 passes B.
REQ-016 MULU: {R,Q}=A*B unsigned, 2*WIDTH-bit exact.
REQ-017 DIVU: Q=A/B, R=A%B unsigned; B=0 gives Q=all ones, R=A, overflow=1.
REQ-018 overflow: ADD carry-out; SUB/NEG/cmp carry-out of A+~B+1 (NEG uses A=0); shifts/rotates last bit shifted out (0 if s=0); MULU R!=0; DIVU B=0; others 0.
REQ-019 less/equal/greater: only SCMP (signed) and UCMP (unsigned), comparing A to B, exactly one set; 0 for all other ops.
REQ-020 zero = (Q==0) for every op.
REQ-021 FSM states IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE.
REQ-022 IDLE & in_valid: MULU -> MUL, DIVU -> DIV, any other -> DONE with result registered; operands latched on accept.
REQ-023 Single-cycle ops: out_valid asserts first cycle after acceptance (latency 1).
REQ-024 MUL: shift-add, one bit per cycle, WIDTH cycles, then DONE; out_valid exactly WIDTH+1 cycles after acceptance.
REQ-025 DIV: restoring, one quotient bit per cycle, WIDTH cycles, then DONE; same latency as MUL, including B=0.
REQ-026 DONE: out_valid=1; Q, R, flags held stable until out_ready=1; DONE & out_ready -> IDLE next cycle.
REQ-027 No back-to-back acceptance: minimum two cycles between accepts; in_valid ignored outside IDLE.
REQ-028 Illegal opcode: single-cycle, Q=0, R=0, overflow=1, zero=1, compare flags 0.

Reset
REQ-029 rst_n low forces IDLE immediately, any operation in flight discarded.
REQ-030 Reset values: in_ready=1, out_valid=0, Q=0, R=0, all flags 0.

Configuration
REQ-031 Macro ALU_SEQ_DIV_EN: defined -> DIV state and divider datapath built, DIVU per REQ-017/025.
REQ-032 Without ALU_SEQ_DIV_EN: no DIV state or divider logic; DIVU handled as illegal opcode per REQ-028.

Structure
REQ-033 Package alu_pkg holds alu_op_e enum, FSM state enum, and flags struct {overflow, less, equal, greater, zero}.
REQ-034 Sub-module alu_seq_iter holds the iterative MUL/DIV datapath (start, op select, done, WIDTH-parametrised); single-cycle ops and FSM stay in alu_seq.

Verification (WIDTH=16)
REQ-035 ADD A=FFFF B=0001 -> Q=0000, overflow=1, zero=1, out_valid one cycle after accept.
REQ-036 MULU A=1234 B=0100 -> Q=3400, R=0012, overflow=1, out_valid exactly 17 cycles after accept.
REQ-037 DIVU A=0064 B=0007 -> Q=000E, R=0002, overflow=0; DIVU A=1234 B=0000 -> Q=FFFF, R=1234, overflow=1; both 17-cycle latency.
REQ-038 SCMP A=0001 B=8000 -> greater=1; UCMP same operands -> less=1; ARS B=8000 A=0003 -> Q=F000.
REQ-039 Backpressure: out_ready low 5 cycles after DONE -> Q/R/flags stable, in_ready=0, new in_valid ignored.
REQ-040 rst_n pulsed low mid-MULU (cycle 8) -> out_valid=0, in_ready=1, Q=0 immediately; next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the alu_seq sequential ALU: opcodes, FSM states and result flags.
// ALU_SEQ_DIV_EN adds the DIV state used by the iterative divider.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_NEG  = 4'd2,
    OP_SCMP = 4'd3,
    OP_UCMP = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_ARS  = 4'd9,
    OP_LRS  = 4'd10,
    OP_LROT = 4'd11,
    OP_RROT = 4'd12,
    OP_MULU = 4'd13,
    OP_DIVU = 4'd14,
    OP_ILL  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef ALU_SEQ_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } alu_state_e;

  typedef struct packed {
    logic overflow;
    logic less;
    logic equal;
    logic greater;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative shift-add multiplier and (with ALU_SEQ_DIV_EN) restoring divider, one bit per cycle.
// done flags the cycle whose clock edge performs the final step; resLo/resHi carry that step's result.
module alu_seq_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ALU_SEQ_DIV_EN
  input  logic             isDiv,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] resLo,
  output logic [WIDTH-1:0] resHi
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH-1:0] hiReg, loReg, opnd;
  logic [WIDTH-1:0] hiNext, loNext;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mulSum;

  assign addend = loReg[0] ? opnd : '0;
  assign mulSum = {1'b0, hiReg} + {1'b0, addend};

`ifdef ALU_SEQ_DIV_EN
  logic           divMode;
  logic [WIDTH:0] remShift, remDiff;

  // remShift < 2*divisor keeps the difference within WIDTH+1 bits; bit WIDTH is the borrow
  assign remShift = {hiReg, loReg[WIDTH-1]};
  assign remDiff  = remShift - {1'b0, opnd};
`endif

  always_comb begin
    hiNext = mulSum[WIDTH:1];
    loNext = {mulSum[0], loReg[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    if (divMode) begin
      if (remDiff[WIDTH]) begin
        hiNext = remShift[WIDTH-1:0];
        loNext = {loReg[WIDTH-2:0], 1'b0};
      end else begin
        hiNext = remDiff[WIDTH-1:0];
        loNext = {loReg[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  assign done  = busy && (cnt == CW'(WIDTH - 1));
  assign resLo = loNext;
  assign resHi = hiNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
`ifdef ALU_SEQ_DIV_EN
      divMode <= 1'b0;
`endif
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
`ifdef ALU_SEQ_DIV_EN
      divMode <= isDiv;
`endif
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      hiReg <= '0;
`ifdef ALU_SEQ_DIV_EN
      loReg <= isDiv ? a : b;
      opnd  <= isDiv ? b : a;
`else
      loReg <= b;
      opnd  <= a;
`endif
    end else if (busy) begin
      hiReg <= hiNext;
      loReg <= loNext;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops computed and registered on accept, MULU/DIVU run in alu_seq_iter.
// ALU_SEQ_DIV_EN builds the divider; without it DIVU behaves as the illegal opcode.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             overflow,
  output logic             less,
  output logic             equal,
  output logic             greater,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);
  typedef logic [SW:0] shAmt_t;

  alu_op_e    opIn;
  alu_state_e stateReg, stateNext;

  logic              iterStart, iterDone, loadSingle, loadIter;
  logic [WIDTH-1:0]  iterLo, iterHi;
  logic [WIDTH-1:0]  qReg, rReg, sQ;
  alu_flags_t        flagsReg, sFlags, iterFlags;

  logic [SW-1:0]           shAmt;
  shAmt_t                  shAmtInv;
  logic [WIDTH:0]          addSum, subDiff, negDiff, rOutVec, lOutVec;
  logic signed [WIDTH-1:0] aSigned, bSigned, arsRes;
  logic [WIDTH-1:0]        rotL, rotR;
  logic                    sLess, uLess, cmpLess;

  assign opIn = alu_op_e'(op);

  assign shAmt    = A[SW-1:0];
  assign shAmtInv = shAmt_t'(WIDTH) - {1'b0, shAmt};
  assign addSum   = {1'b0, A} + {1'b0, B};
  assign subDiff  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign negDiff  = {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign aSigned  = A;
  assign bSigned  = B;
  assign arsRes   = bSigned >>> shAmt;
  assign rotL     = (B << shAmt) | (B >> shAmtInv);
  assign rotR     = (B >> shAmt) | (B << shAmtInv);
  // Last bit shifted out lands in bit 0 / bit WIDTH; a zero shift leaves the padding bit there
  assign rOutVec  = {B, 1'b0} >> shAmt;
  assign lOutVec  = {1'b0, B} << shAmt;
  assign sLess    = aSigned < bSigned;
  assign uLess    = A < B;
  assign cmpLess  = (opIn == OP_SCMP) ? sLess : uLess;

  always_comb begin
    sQ     = '0;
    sFlags = '0;
    case (opIn)
      OP_ADD: begin
        sQ              = addSum[WIDTH-1:0];
        sFlags.overflow = addSum[WIDTH];
      end
      OP_SUB: begin
        sQ              = subDiff[WIDTH-1:0];
        sFlags.overflow = subDiff[WIDTH];
      end
      OP_SCMP, OP_UCMP: begin
        sQ              = subDiff[WIDTH-1:0];
        sFlags.overflow = subDiff[WIDTH];
        sFlags.less     = cmpLess;
        sFlags.equal    = (A == B);
        sFlags.greater  = !cmpLess && (A != B);
      end
      OP_NEG: begin
        sQ              = negDiff[WIDTH-1:0];
        sFlags.overflow = negDiff[WIDTH];
      end
      OP_AND: sQ = A & B;
      OP_OR:  sQ = A | B;
      OP_XOR: sQ = A ^ B;
      OP_NOT: sQ = ~B;
      OP_ARS: begin
        sQ              = arsRes;
        sFlags.overflow = rOutVec[0];
      end
      OP_LRS: begin
        sQ              = B >> shAmt;
        sFlags.overflow = rOutVec[0];
      end
      OP_LROT: begin
        sQ              = rotL;
        sFlags.overflow = lOutVec[WIDTH];
      end
      OP_RROT: begin
        sQ              = rotR;
        sFlags.overflow = rOutVec[0];
      end
      default: sFlags.overflow = 1'b1;
    endcase
    sFlags.zero = (sQ == '0);
  end

  alu_seq_iter #(.WIDTH(WIDTH)) uIter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iterStart),
`ifdef ALU_SEQ_DIV_EN
    .isDiv (opIn == OP_DIVU),
`endif
    .a     (A),
    .b     (B),
    .done  (iterDone),
    .resLo (iterLo),
    .resHi (iterHi)
  );

`ifdef ALU_SEQ_DIV_EN
  logic bZeroReg;

  always_ff @(posedge clk) begin
    if (iterStart) bZeroReg <= (B == '0);
  end
`endif

  always_comb begin
    iterFlags          = '0;
    iterFlags.overflow = (iterHi != '0);
`ifdef ALU_SEQ_DIV_EN
    if (stateReg == S_DIV) iterFlags.overflow = bZeroReg;
`endif
    iterFlags.zero = (iterLo == '0);
  end

  always_comb begin
    stateNext  = stateReg;
    iterStart  = 1'b0;
    loadSingle = 1'b0;
    loadIter   = 1'b0;
    case (stateReg)
      S_IDLE: begin
        if (in_valid) begin
          if (opIn == OP_MULU) begin
            stateNext = S_MUL;
            iterStart = 1'b1;
          end
`ifdef ALU_SEQ_DIV_EN
          else if (opIn == OP_DIVU) begin
            stateNext = S_DIV;
            iterStart = 1'b1;
          end
`endif
          else begin
            stateNext  = S_DONE;
            loadSingle = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (iterDone) begin
          stateNext = S_DONE;
          loadIter  = 1'b1;
        end
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        if (iterDone) begin
          stateNext = S_DONE;
          loadIter  = 1'b1;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateReg <= S_IDLE;
    else        stateReg <= stateNext;
  end

  // Results stay frozen while DONE waits for out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qReg     <= '0;
      rReg     <= '0;
      flagsReg <= '0;
    end else if (loadSingle) begin
      qReg     <= sQ;
      rReg     <= '0;
      flagsReg <= sFlags;
    end else if (loadIter) begin
      qReg     <= iterLo;
      rReg     <= iterHi;
      flagsReg <= iterFlags;
    end
  end

  assign in_ready  = (stateReg == S_IDLE);
  assign out_valid = (stateReg == S_DONE);
  assign Q         = qReg;
  assign R         = rReg;
  assign overflow  = flagsReg.overflow;
  assign less      = flagsReg.less;
  assign equal     = flagsReg.equal;
  assign greater   = flagsReg.greater;
  assign zero      = flagsReg.zero;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): vector table with scoreboard queue plus backpressure/reset sequences.
// DIVU expectations follow ALU_SEQ_DIV_EN (divider result when defined, illegal-opcode result otherwise).
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   op = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] Q, R;
  logic         overflow, less, equal, greater, zero;
  logic [4:0]   flg;

  assign flg = {overflow, less, equal, greater, zero};

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .overflow  (overflow),
    .less      (less),
    .equal     (equal),
    .greater   (greater),
    .zero      (zero)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [4:0]   f;
    int           lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] q, input logic [W-1:0] r, input logic [4:0] f,
                              input int lat);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.q = q; v.r = r; v.f = f; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic runVec(input int idx, input vec_t v);
    vec_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_in_ready", idx), {31'b0, in_ready}, 32'd1);
    op = v.op; A = v.a; B = v.b; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'($urandom);
    A  = W'($urandom);
    B  = W'($urandom);
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    check($sformatf("v%0d_lat", idx), n, e.lat);
    check($sformatf("v%0d_q", idx), {16'b0, Q}, {16'b0, e.q});
    check($sformatf("v%0d_r", idx), {16'b0, R}, {16'b0, e.r});
    check($sformatf("v%0d_flags", idx), {27'b0, flg}, {27'b0, e.f});
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // flags order: {overflow, less, equal, greater, zero}
    vecs.push_back(mk(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b10001, 1));
    vecs.push_back(mk(OP_ADD,  16'h1234, 16'h1111, 16'h2345, 16'h0000, 5'b00000, 1));
    vecs.push_back(mk(OP_SUB,  16'h0005, 16'h0003, 16'h0002, 16'h0000, 5'b10000, 1));
    vecs.push_back(mk(OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 5'b00000, 1));
    vecs.push_back(mk(OP_NEG,  16'h5555, 16'h0001, 16'hFFFF, 16'h0000, 5'b00000, 1));
    vecs.push_back(mk(OP_NEG,  16'h5555, 16'h0000, 16'h0000, 16'h0000, 5'b10001, 1));
    vecs.push_back(mk(OP_SCMP, 16'h0001, 16'h8000, 16'h8001, 16'h0000, 5'b00010, 1));
    vecs.push_back(mk(OP_UCMP, 16'h0001, 16'h8000, 16'h8001, 16'h0000, 5'b01000, 1));
    vecs.push_back(mk(OP_SCMP, 16'h7777, 16'h7777, 16'h0000, 16'h0000, 5'b10101, 1));
    vecs.push_back(mk(OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 5'b00000, 1));
    vecs.push_back(mk(OP_OR,   16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 5'b00000, 1));
    vecs.push_back(mk(OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 5'b00001, 1));
    vecs.push_back(mk(OP_NOT,  16'h1234, 16'h00FF, 16'hFF00, 16'h0000, 5'b00000, 1));
    vecs.push_back(mk(OP_ARS,  16'h0003, 16'h8000, 16'hF000, 16'h0000, 5'b00000, 1));
    vecs.push_back(mk(OP_ARS,  16'h000F, 16'h8000, 16'hFFFF, 16'h0000, 5'b00000, 1));
    vecs.push_back(mk(OP_LRS,  16'h0004, 16'h8018, 16'h0801, 16'h0000, 5'b10000, 1));
    vecs.push_back(mk(OP_LRS,  16'h0010, 16'hABCD, 16'hABCD, 16'h0000, 5'b00000, 1));
    vecs.push_back(mk(OP_LROT, 16'h0004, 16'h1234, 16'h2341, 16'h0000, 5'b10000, 1));
    vecs.push_back(mk(OP_RROT, 16'h0008, 16'h1234, 16'h3412, 16'h0000, 5'b00000, 1));
    vecs.push_back(mk(OP_MULU, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 5'b10000, 17));
    vecs.push_back(mk(OP_MULU, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 5'b10000, 17));
    vecs.push_back(mk(OP_MULU, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 5'b00000, 17));
    vecs.push_back(mk(OP_MULU, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 5'b00001, 17));
`ifdef ALU_SEQ_DIV_EN
    vecs.push_back(mk(OP_DIVU, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 5'b00000, 17));
    vecs.push_back(mk(OP_DIVU, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 5'b10000, 17));
    vecs.push_back(mk(OP_DIVU, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 5'b00001, 17));
`else
    vecs.push_back(mk(OP_DIVU, 16'h0064, 16'h0007, 16'h0000, 16'h0000, 5'b10001, 1));
    vecs.push_back(mk(OP_DIVU, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 5'b10001, 1));
`endif
    vecs.push_back(mk(OP_ILL,  16'h1234, 16'h5678, 16'h0000, 16'h0000, 5'b10001, 1));

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_q", {16'b0, Q}, 32'd0);
    check("rst_r", {16'b0, R}, 32'd0);
    check("rst_flags", {27'b0, flg}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) runVec(i, vecs[i]);

    // backpressure: result held 5 cycles while new requests are offered
    @(negedge clk);
    op = OP_ADD; A = 16'h1234; B = 16'h1111; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = OP_SUB; A = W'($urandom); B = W'($urandom);
      @(negedge clk);
      check($sformatf("bp%0d_q", i), {16'b0, Q}, 32'h2345);
      check($sformatf("bp%0d_r", i), {16'b0, R}, 32'h0);
      check($sformatf("bp%0d_flags", i), {27'b0, flg}, 32'd0);
      check($sformatf("bp%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
      check($sformatf("bp%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);

    // reset in the middle of a MULU
    op = OP_MULU; A = 16'h1234; B = 16'h0100; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_q", {16'b0, Q}, 32'd0);
    check("mid_rst_r", {16'b0, R}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_result", {31'b0, out_valid}, 32'd0);
    runVec(100, mk(OP_ADD, 16'h0101, 16'h0202, 16'h0303, 16'h0000, 5'b00000, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
